// File: rtl/serial_pkg.sv
// Shared definitions for the lab serial link (transmitter now, receiver later):
// FSM state encoding, line levels and the even-parity helper.
package serial_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Words narrower than 16 bits are zero-extended by the caller.
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 on the falling edge and pulses
// tick at terminal count; clr restarts the period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // With CLKS_PER_BIT=1 the counter is pinned at 0, so tick is constantly 1.
    assign tick = (cnt_r == LAST_CNT);

    // Period counter, wraps at terminal count.
    always_ff @(negedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, optional
// even parity (compiled in with SERIAL_TX_PARITY_EN), stop bit. tx/tx_n registered.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              tx_n,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state_r;
    tx_state_t         state_nxt_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              tx_r;
    logic              tx_n_r;
    logic              busy_r;
    logic              ready_r;
    logic              tx_nxt_s;
    logic              tick_s;
    logic              clr_s;
    logic              accept_s;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // ready_r is only ever high in IDLE, so it alone gates acceptance.
    assign accept_s = din_valid && ready_r;
    assign clr_s    = (state_nxt_s != state_r);

`ifdef SERIAL_TX_PARITY_EN
    logic par_r;

    // Parity snapshot of the accepted word, independent of the shifting copy.
    always_ff @(negedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (accept_s) begin
            par_r <= even_parity(16'(din));
        end else begin
            par_r <= par_r;
        end
    end
`endif

    // Next state, shift register and bit index.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                    shift_nxt_s = din;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_nxt_s = ST_DATA;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_nxt_s = shift_r >> 1;
                    idx_nxt_s   = idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx is registered yet on time.
    always_comb begin
        tx_nxt_s = LINE_IDLE;
        case (state_nxt_s)
            ST_IDLE:   tx_nxt_s = LINE_IDLE;
            ST_START:  tx_nxt_s = START_LVL;
            ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_nxt_s = par_r;
`endif
            ST_STOP:   tx_nxt_s = STOP_LVL;
            default:   tx_nxt_s = LINE_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shift_r <= {DATA_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            tx_r    <= LINE_IDLE;
            tx_n_r  <= ~LINE_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            idx_r   <= idx_nxt_s;
            tx_r    <= tx_nxt_s;
            tx_n_r  <= ~tx_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    assign tx        = tx_r;
    assign tx_n      = tx_n_r;
    assign busy      = busy_r;
    assign din_ready = ready_r;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a CLKS_PER_BIT=4 instance and a CLKS_PER_BIT=1 instance,
// expected per-cycle line/busy values queued from a frame model and popped each cycle.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SLOW_CPB = 4;
    localparam int FRAME_A  = (8 + 2 + PAR_BITS) * SLOW_CPB;

    typedef struct {
        logic tx;
        logic busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       din_valid_a, din_valid_b;
    logic       din_ready_a, din_ready_b;
    logic       tx_a, tx_b, tx_n_a, tx_n_b, busy_a, busy_b;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(SLOW_CPB)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid_a),
        .din_ready(din_ready_a), .tx(tx_a), .tx_n(tx_n_a), .busy(busy_a)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b),
        .din_ready(din_ready_b), .tx(tx_b), .tx_n(tx_n_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_slot(input logic v, input int cpb);
        repeat (cpb) exp_q.push_back('{tx: v, busy: 1'b1});
    endtask

    task automatic push_frame(input logic [7:0] w, input int cpb);
        push_slot(1'b0, cpb);
        for (int i = 0; i < 8; i++) push_slot(w[i], cpb);
        if (PAR_BITS == 1) push_slot(^w, cpb);
        push_slot(1'b1, cpb);
    endtask

    task automatic push_idle();
        exp_q.push_back('{tx: 1'b1, busy: 1'b0});
    endtask

    task automatic drain(input int sel, input int n);
        exp_t e;
        int   k;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                k = total;
                if (sel == 0) begin
                    chk($sformatf("a.tx@%0d", k), tx_a, e.tx);
                    chk($sformatf("a.tx_n@%0d", k), tx_n_a, ~e.tx);
                    chk($sformatf("a.busy@%0d", k), busy_a, e.busy);
                    chk($sformatf("a.din_ready@%0d", k), din_ready_a, ~e.busy);
                end else begin
                    chk($sformatf("b.tx@%0d", k), tx_b, e.tx);
                    chk($sformatf("b.tx_n@%0d", k), tx_n_b, ~e.tx);
                    chk($sformatf("b.busy@%0d", k), busy_b, e.busy);
                    chk($sformatf("b.din_ready@%0d", k), din_ready_b, ~e.busy);
                end
            end
        end
    endtask

    // One frame, din_valid dropped and din scrambled right after acceptance.
    task automatic send(input int sel, input logic [7:0] w, input int cpb);
        if (sel == 0) begin
            din_a = w;
            din_valid_a = 1'b1;
        end else begin
            din_b = w;
            din_valid_b = 1'b1;
        end
        push_frame(w, cpb);
        push_idle();
        drain(sel, 1);
        if (sel == 0) begin
            din_valid_a = 1'b0;
            din_a = ~w;
        end else begin
            din_valid_b = 1'b0;
            din_b = ~w;
        end
        drain(sel, exp_q.size());
    endtask

    initial begin
        rst = 1'b1;
        din_a = 8'hA5;
        din_valid_a = 1'b1;
        din_b = 8'h81;
        din_valid_b = 1'b1;

        // three falling edges under reset, din_valid held high
        repeat (4) @(posedge clk);
        chk("rst.a.tx", tx_a, 1'b1);
        chk("rst.a.tx_n", tx_n_a, 1'b0);
        chk("rst.a.busy", busy_a, 1'b0);
        chk("rst.a.din_ready", din_ready_a, 1'b0);
        chk("rst.b.tx", tx_b, 1'b1);
        chk("rst.b.tx_n", tx_n_b, 1'b0);
        chk("rst.b.busy", busy_b, 1'b0);
        chk("rst.b.din_ready", din_ready_b, 1'b0);

        rst = 1'b0;
        @(posedge clk);
        chk("rel.a.din_ready", din_ready_a, 1'b1);
        chk("rel.a.busy", busy_a, 1'b0);
        chk("rel.a.tx", tx_a, 1'b1);
        chk("rel.b.din_ready", din_ready_b, 1'b1);
        chk("rel.b.busy", busy_b, 1'b0);
        din_valid_a = 1'b0;
        din_valid_b = 1'b0;
        @(posedge clk);

        send(0, 8'hA5, SLOW_CPB);
        send(0, 8'h07, SLOW_CPB);

        // back-to-back: valid held high, din switched to 0xFF mid-frame
        din_a = 8'h00;
        din_valid_a = 1'b1;
        push_frame(8'h00, SLOW_CPB);
        push_idle();
        push_frame(8'hFF, SLOW_CPB);
        push_idle();
        drain(0, 1);
        din_a = 8'hFF;
        drain(0, FRAME_A + 1);
        din_valid_a = 1'b0;
        din_a = 8'h5A;
        drain(0, exp_q.size());

        // reset during data bit 3
        din_a = 8'h00;
        din_valid_a = 1'b1;
        repeat (4 * SLOW_CPB + 1) exp_q.push_back('{tx: 1'b0, busy: 1'b1});
        drain(0, 1);
        din_valid_a = 1'b0;
        drain(0, exp_q.size());
        rst = 1'b1;
        @(posedge clk);
        chk("abort.a.tx", tx_a, 1'b1);
        chk("abort.a.tx_n", tx_n_a, 1'b0);
        chk("abort.a.busy", busy_a, 1'b0);
        chk("abort.a.din_ready", din_ready_a, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        chk("abort.a.ready_back", din_ready_a, 1'b1);
        send(0, 8'h3C, SLOW_CPB);

        send(1, 8'h81, 1);
        send(1, 8'h5E, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Serial frame transmitter for the lab datapath: accepts a parallel word on a valid/ready handshake and drives it onto a single line as start bit, data LSB-first, optional parity and stop bit. It is the transmit end of the lab serial link. Its line output is captured bit-by-bit by the flip-flop-based receiver stage, so it presents the same true/complement output pair as the team's D flip-flop.

## Interface
- DATA_W, 8: data bits per frame, 1..16
- CLKS_PER_BIT, 4: clk cycles each bit is held on the line, ≥1
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  reset rst, synchronous, active-high
- din  in  DATA_W  word to send
- din_valid  in  1  din is presented
- din_ready  out  1  block can accept a word this cycle
- tx  out  1  serial line, idle high
- tx_n  out  1  always ~tx
- busy  out  1  frame in progress

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: tx=1, din_ready=1, busy=0.
- Accept: falling edge with din_valid && din_ready.
  - din is latched into the shift register.
  - Go to START, drive tx=0, busy=1, din_ready=0.
- Bit timer counts 0..CLKS_PER_BIT-1 and pulses at terminal count.
  - Counter width is $clog2(CLKS_PER_BIT), minimum 1.
  - Reset to 0 on every state change.
- START → DATA on tick.
- DATA: tx = shift_reg[0]; shift right on tick.
  - Bit index runs 0..DATA_W-1.
  - After the tick of bit DATA_W-1, go to PARITY if enabled, otherwise STOP.
- PARITY: tx = even parity of the latched word (XOR of all bits).
  - Computed from a copy held at accept, not from the shifting register.
- STOP: tx=1 for CLKS_PER_BIT cycles; on tick go to IDLE.
- din and din_valid are ignored while busy.
  - din may change freely after the accept edge.
- tx and tx_n are registered; no combinational path from din to tx.

## Timing
- Reset values, after any falling edge with rst=1:
  - tx=1, tx_n=0, busy=0, din_ready=0, state IDLE, counters 0.
  - din_ready rises on the first edge with rst=0.
- Reset mid-frame aborts the frame; the line returns to tx=1 on that same edge.
- Latency: tx goes low on the accept edge itself.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- din_ready is 1 in the cycle after the last stop-bit cycle.
  - Back-to-back words have a minimum 1-cycle idle-high gap between stop and the next start.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; the tick is constant 1.
- DATA_W=1: DATA lasts one bit period.
- din_valid asserted during rst is not accepted.

## Configuration
- SERIAL_TX_PARITY_EN
  - Defined: PARITY state compiled in; frame carries an even-parity bit between data and stop.
  - Undefined: PARITY state and parity logic absent; DATA goes directly to STOP.

## Structure
- Package serial_pkg holds:
  - state enum tx_state_t
  - LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1
  - function even_parity
  - The future receiver shares this package.
- One sub-module, bit_timer.
  - Parameter CLKS_PER_BIT; inputs clk, rst, clr; output tick.
  - Counts on the falling edge.
- The FSM, shift register and bit index stay in serial_tx.

## Test plan
- Reset: hold rst 3 cycles → tx=1, tx_n=0, busy=0, din_ready=0; first edge with rst=0 → din_ready=1.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, din=0xA5, parity off:
  - tx per 4-cycle slot = 0,1,0,1,0,0,1,0,1,1.
  - busy high 40 cycles, then din_ready=1.
- Parity on, din=0xA5: parity slot tx=0, frame 44 cycles. Parity on, din=0x07: parity slot tx=1.
- Back-to-back: din_valid held high with 0x00 then 0xFF.
  - Second start bit begins exactly 1 cycle after the first frame's stop ends.
  - din changed during the first frame has no effect on it.
- Reset mid-frame: assert rst during data bit 3 → tx=1 on that edge, busy=0; a new 0x3C afterwards is transmitted correctly.
- CLKS_PER_BIT=1, din=0x81: tx = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; tx_n is the complement every cycle.
